// File: rtl/bios_boot_watchdog.sv
// Boot-progress watchdog: arms on WdtEnable, expects BootDone before TICK_DIV*TIMEOUT_TICKS cycles,
// otherwise commits the alternate BIOS (Next_Bios_latch), pulses SysResetReq, then halts.
// Latency: all outputs registered, one edge after the deciding input; no backpressure (strobe-driven).
module bios_boot_watchdog #(
  parameter int TICK_DIV      = 33000,
  parameter int TIMEOUT_TICKS = 60000,
  parameter int RST_PULSE_CYC = 330
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       WdtEnable,
  input  logic       BootDone,
  input  logic       WdtKick,
  input  logic       Current_Bios,
  input  logic       Next_Bios,
  input  logic       Active_Bios,
  output logic       Next_Bios_latch,
  output logic       SysResetReq,
  output logic       WdtExpired,
  output logic       FailBios,
  output logic       SameBiosFail,
  output logic [2:0] WdtState
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_DONE   = 3'd2,
    S_EXPIRE = 3'd3,
    S_RSTREQ = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] TICK_LAST  = 16'(TIMEOUT_TICKS - 1);
  localparam logic [15:0] TICK_MAX   = 16'(TIMEOUT_TICKS);
  localparam logic [15:0] PULSE_LAST = 16'(RST_PULSE_CYC - 1);

  state_t      state, state_next;
  logic [15:0] presc, presc_next;
  logic [15:0] tick_cnt, tick_next;
  logic        expired_next, fail_next, same_next;
  logic        is_tick;

  // Current_Bios is informational only; it never steers the watchdog.
  logic unused_current_bios;
  assign unused_current_bios = Current_Bios;

  // The prescaler wrap cycle is the watchdog tick.
  assign is_tick = (presc == PRESC_LAST);

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_next   = state;
    presc_next   = presc;
    tick_next    = tick_cnt;
    expired_next = WdtExpired;
    fail_next    = FailBios;
    same_next    = SameBiosFail;
    case (state)
      S_IDLE: begin
        presc_next = '0;
        tick_next  = '0;
        if (WdtEnable) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (!WdtEnable) begin
          state_next = S_IDLE;
          presc_next = '0;
          tick_next  = '0;
        end else if (BootDone) begin
          // BootDone outranks a coincident expiry; counters freeze from here.
          state_next = S_DONE;
        end else if (WdtKick) begin
          presc_next = '0;
          tick_next  = '0;
        end else if (is_tick) begin
          presc_next = '0;
          if (tick_cnt < TICK_MAX) tick_next = tick_cnt + 16'd1;
          if (tick_cnt >= TICK_LAST) state_next = S_EXPIRE;
        end else begin
          presc_next = presc + 16'd1;
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      S_EXPIRE: begin
        expired_next = 1'b1;
        fail_next    = Active_Bios;
        same_next    = (Next_Bios == Active_Bios);
        presc_next   = '0;   // prescaler doubles as the reset-pulse counter
        state_next   = S_RSTREQ;
      end
      S_RSTREQ: begin
        if (presc >= PULSE_LAST) begin
          presc_next = '0;
          state_next = S_HALT;
        end else begin
          presc_next = presc + 16'd1;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
        presc_next = '0;
        tick_next  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) begin
      state           <= S_IDLE;
      presc           <= '0;
      tick_cnt        <= '0;
      Next_Bios_latch <= 1'b0;
      SysResetReq     <= 1'b0;
      WdtExpired      <= 1'b0;
      FailBios        <= 1'b0;
      SameBiosFail    <= 1'b0;
    end else begin
      state           <= state_next;
      presc           <= presc_next;
      tick_cnt        <= tick_next;
      Next_Bios_latch <= (state_next == S_EXPIRE);
      SysResetReq     <= (state_next == S_RSTREQ);
      WdtExpired      <= expired_next;
      FailBios        <= fail_next;
      SameBiosFail    <= same_next;
    end
  end

  assign WdtState = state;

endmodule
